traffic_light_monitor: RTL and testbench

Passive checker for the lamp interface driven by the traffic controller. It watches red/green/yellow and the condition input, decodes the current phase, and measures each phase's duration in clk cycles. It flags illegal lamp patterns, illegal phase order, wrong phase lengths and stuck lamps. It sits beside the controller in system benches and in silicon as a safety observer, sharing clk and rst with it.

---
 rtl/traffic_pkg.sv | 47 ++++
 rtl/traffic_light_monitor_if.sv | 46 ++++
 rtl/traffic_phase_timer.sv | 53 +++++
 rtl/traffic_light_monitor.sv | 156 +++++++++++++++
 tb/tb_traffic_light_monitor.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic-light controller and its
// monitor. Phase encodings, monitor FSM states, the stage-1 lamp sample
// struct, default timing constants, and the lamp decode / legal-step helpers.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_RED     = 2'b00,
    PH_GREEN   = 2'b01,
    PH_YELLOW  = 2'b10,
    PH_INVALID = 2'b11
  } phase_t;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_t;

  typedef struct packed {
    logic red;
    logic green;
    logic yellow;
    logic cond;
  } lamp_sample_t;

  localparam int TL_SHORT_LEN = 32;
  localparam int TL_LONG_LEN  = 64;
  localparam int TL_YEL_LEN   = 5;
  localparam int TL_STUCK_LEN = 200;
  localparam int TL_CNT_W     = 8;

  // Exactly one lamp lit gives a phase; anything else is INVALID.
  function automatic phase_t decode_phase(input logic r, input logic g, input logic y);
    case ({r, g, y})
      3'b100:  return PH_RED;
      3'b010:  return PH_GREEN;
      3'b001:  return PH_YELLOW;
      default: return PH_INVALID;
    endcase
  endfunction

  function automatic logic legal_step(input phase_t from, input phase_t to);
    return ((from == PH_RED)    && (to == PH_GREEN))  ||
           ((from == PH_GREEN)  && (to == PH_YELLOW)) ||
           ((from == PH_YELLOW) && (to == PH_RED));
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: lamp observation bus plus monitor results.
//   lamps/condition/clr_err : driven by the observed system (master)
//   phase .. err_any        : driven by the monitor (slave)
//   cycle_cnt               : present only when TLM_COVER_EN is defined
interface traffic_light_monitor_if
  import traffic_pkg::*;
#(
  parameter int CNT_W = TL_CNT_W
) ();

  logic             red;
  logic             green;
  logic             yellow;
  logic             condition;
  logic             clr_err;
  phase_t           phase;
  logic             len_valid;
  logic [CNT_W-1:0] phase_len;
  logic             err_onehot;
  logic             err_seq;
  logic             err_len;
  logic             err_stuck;
  logic             err_any;
`ifdef TLM_COVER_EN
  logic [15:0]      cycle_cnt;
`endif

  modport master (
    output red, green, yellow, condition, clr_err,
    input  phase, len_valid, phase_len, err_onehot, err_seq, err_len,
           err_stuck, err_any
`ifdef TLM_COVER_EN
    , input cycle_cnt
`endif
  );

  modport slave (
    input  red, green, yellow, condition, clr_err,
    output phase, len_valid, phase_len, err_onehot, err_seq, err_len,
           err_stuck, err_any
`ifdef TLM_COVER_EN
    , output cycle_cnt
`endif
  );

endinterface

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: per-phase run counter and condition-stability tracker.
//   en          : a valid sample is present this cycle
//   load        : the sample starts a new phase (counter loads 1)
//   cond        : condition seen with the sample
//   run_cnt     : cycles spent in the current phase, saturating
//   run_nxt     : value run_cnt takes at the next edge (lets the top
//                 register level errors in step with the counter)
//   cond_stable : condition has not changed since the phase began
//   cond_ref    : condition at phase start; equals the last-cycle value
//                 whenever cond_stable is set
module traffic_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             cond,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] run_nxt,
  output logic             cond_stable,
  output logic             cond_ref
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_comb begin
    run_nxt = run_cnt;
    if (en) begin
      if (load)                    run_nxt = CNT_W'(1);
      else if (run_cnt != CNT_MAX) run_nxt = run_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt     <= '0;
      cond_stable <= 1'b0;
      cond_ref    <= 1'b0;
    end else begin
      run_cnt <= run_nxt;
      if (en) begin
        if (load) begin
          cond_stable <= 1'b1;
          cond_ref    <= cond;
        end else if (cond != cond_ref) begin
          cond_stable <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive safety observer for the traffic lamps.
// Stage 1 samples red/green/yellow/condition; stage 2 decodes the phase,
// runs the SYNC/TRACK FSM, checks order/length/one-hot/stuck and registers
// every output (2-cycle latency).
//   clk, rst : shared with the controller (rst synchronous, active-high)
//   mon      : traffic_light_monitor_if.slave (lamps in, results out)
// Optional: define TLM_COVER_EN to add mon.cycle_cnt, the count of
// completed error-free RED->GREEN->YELLOW->RED rounds.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int SHORT_LEN = TL_SHORT_LEN,
  parameter int LONG_LEN  = TL_LONG_LEN,
  parameter int YEL_LEN   = TL_YEL_LEN,
  parameter int STUCK_LEN = TL_STUCK_LEN,
  parameter int CNT_W     = TL_CNT_W
) (
  input logic                    clk,
  input logic                    rst,
  traffic_light_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] SHORT_L = CNT_W'(SHORT_LEN);
  localparam logic [CNT_W-1:0] LONG_L  = CNT_W'(LONG_LEN);
  localparam logic [CNT_W-1:0] YEL_L   = CNT_W'(YEL_LEN);
  localparam logic [CNT_W-1:0] STUCK_L = CNT_W'(STUCK_LEN);

  // Stage 1 and its valid pipe: [0] stage 1 holds a real sample,
  // [1] stage 2 has already taken a sample (a previous phase exists).
  lamp_sample_t s1_q;
  logic [1:0]   vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      vld_pipe <= '0;
    end else begin
      s1_q     <= '{red: mon.red, green: mon.green, yellow: mon.yellow, cond: mon.condition};
      vld_pipe <= {vld_pipe[0], 1'b1};
    end
  end

  phase_t           cur_ph, ph_q;
  logic             sample, first, change;
  logic [CNT_W-1:0] run_cnt, run_nxt, exp_len;
  logic             cond_stable, cond_ref;

  assign cur_ph = decode_phase(s1_q.red, s1_q.green, s1_q.yellow);
  assign sample = vld_pipe[0];
  // The first sample after reset only seeds the phase; it is never a change.
  assign first  = vld_pipe[0] & ~vld_pipe[1];
  assign change = vld_pipe[0] & vld_pipe[1] & (cur_ph != ph_q);

  traffic_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (sample),
    .load        (first | change),
    .cond        (s1_q.cond),
    .run_cnt     (run_cnt),
    .run_nxt     (run_nxt),
    .cond_stable (cond_stable),
    .cond_ref    (cond_ref)
  );

  mon_state_t state_q, state_nxt;
  logic       skip_q, skip_nxt;
  logic       oh_nxt, seq_nxt, len_nxt, stuck_nxt, err_now, any_nxt;
  logic       len_valid_q, oh_q, seq_q, lenerr_q, stuck_q, any_q;
  logic [CNT_W-1:0] len_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_SYNC;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    skip_nxt  = skip_q;
    seq_nxt   = 1'b0;
    len_nxt   = 1'b0;
    oh_nxt    = sample & (cur_ph == PH_INVALID);
    stuck_nxt = run_nxt > STUCK_L;
    if (ph_q == PH_YELLOW) exp_len = YEL_L;
    else if (cond_ref)     exp_len = LONG_L;
    else                   exp_len = SHORT_L;
    if (change) begin
      seq_nxt   = ~legal_step(ph_q, cur_ph);
      // The ended phase is checked only when its start was properly
      // observed: not the first phase (SYNC), not INVALID, not entered
      // from INVALID, and with condition steady throughout.
      len_nxt   = (state_q == ST_TRACK) & ~skip_q & (ph_q != PH_INVALID) &
                  cond_stable & (run_cnt != exp_len);
      skip_nxt  = (ph_q == PH_INVALID);
      state_nxt = ST_TRACK;
    end
    err_now = oh_nxt | seq_nxt | len_nxt | stuck_nxt;
    // A new error outranks a simultaneous clear.
    any_nxt = (any_q & ~mon.clr_err) | err_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q        <= PH_RED;
      len_valid_q <= 1'b0;
      len_q       <= '0;
      oh_q        <= 1'b0;
      seq_q       <= 1'b0;
      lenerr_q    <= 1'b0;
      stuck_q     <= 1'b0;
      any_q       <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      if (sample) ph_q <= cur_ph;
      len_valid_q <= change;
      if (change) len_q <= run_cnt;
      oh_q        <= oh_nxt;
      seq_q       <= seq_nxt;
      lenerr_q    <= len_nxt;
      stuck_q     <= stuck_nxt;
      any_q       <= any_nxt;
      skip_q      <= skip_nxt;
    end
  end

  assign mon.phase      = ph_q;
  assign mon.len_valid  = len_valid_q;
  assign mon.phase_len  = len_q;
  assign mon.err_onehot = oh_q;
  assign mon.err_seq    = seq_q;
  assign mon.err_len    = lenerr_q;
  assign mon.err_stuck  = stuck_q;
  assign mon.err_any    = any_q;

`ifdef TLM_COVER_EN
  // round_ok: a RED entry has been seen and nothing has gone wrong since.
  logic        round_ok_q;
  logic [15:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      round_ok_q <= 1'b0;
      cyc_q      <= '0;
    end else if (sample) begin
      if (change && ph_q == PH_YELLOW && cur_ph == PH_RED && round_ok_q &&
          !err_now && cyc_q != 16'hFFFF)
        cyc_q <= cyc_q + 16'd1;
      if ((first || change) && cur_ph == PH_RED) round_ok_q <= 1'b1;
      else if (err_now)                          round_ok_q <= 1'b0;
    end
  end

  assign mon.cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor. Inputs are logged per cycle;
// expected outputs are recomputed from that history (segments of equal
// decoded phase, counted by index arithmetic) and compared every cycle.
module tb_traffic_light_monitor;

  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_light_monitor_if #(.CNT_W(8)) mon_if ();

  traffic_light_monitor dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if.slave)
  );

  // Input history, index = cycle in which the value was applied.
  bit       rst_h [MAXC];
  bit [1:0] ph_h  [MAXC];
  bit       cnd_h [MAXC];
  bit       clr_h [MAXC];

  int       cyc = 0;
  int       n_assert = 0;
  int       n_fail = 0;
  int       r0 = -1;         // first valid sample index after the last reset
  int       seg_start = 0;   // sample index at which the current phase began
  bit [7:0] plen_m = 0;
  bit       any_m = 0;

  function automatic bit [1:0] dec(input bit r, input bit g, input bit y);
    case ({r, g, y})
      3'b100:  return 2'd0;
      3'b010:  return 2'd1;
      3'b001:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic bit legal(input bit [1:0] a, input bit [1:0] b);
    return (a == 0 && b == 1) || (a == 1 && b == 2) || (a == 2 && b == 0);
  endfunction

  // Is the finished segment [s, e] of length len a length violation?
  function automatic bit seg_len_bad(input int s, input int e, input int len);
    int exp_l;
    if (s == r0 || ph_h[s] == 3 || ph_h[s-1] == 3) return 1'b0;
    for (int i = s; i <= e; i++)
      if (cnd_h[i] != cnd_h[s]) return 1'b0;
    exp_l = (ph_h[s] == 2) ? 5 : (cnd_h[e] ? 64 : 32);
    return len != exp_l;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $display("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
      $error("%s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected outputs just after edge n (edge n samples inputs of cycle n-1).
  task automatic model_check(input int n);
    bit [1:0] e_ph = 0;
    bit e_lv = 0, e_oh = 0, e_seq = 0, e_len = 0, e_st = 0;
    int k, len;
    if (rst_h[n-1]) begin
      plen_m = 0; any_m = 0; r0 = -1;
    end else begin
      k = n - 2;
      if (k < 0 || rst_h[k]) begin
        r0 = n - 1;
      end else begin
        if (k == r0) begin
          seg_start = k;
        end else if (ph_h[k] != ph_h[k-1]) begin
          len = k - seg_start;
          if (len > 255) len = 255;
          e_lv   = 1;
          plen_m = 8'(len);
          e_seq  = !legal(ph_h[k-1], ph_h[k]);
          e_len  = seg_len_bad(seg_start, k - 1, len);
          seg_start = k;
        end
        e_ph  = ph_h[k];
        e_oh  = (ph_h[k] == 3);
        e_st  = (k - seg_start + 1) > 200;
        any_m = (any_m & !clr_h[n-1]) | e_oh | e_seq | e_len | e_st;
      end
    end
    chk("phase",      16'(mon_if.phase),      16'(e_ph));
    chk("len_valid",  16'(mon_if.len_valid),  16'(e_lv));
    chk("phase_len",  16'(mon_if.phase_len),  16'(plen_m));
    chk("err_onehot", 16'(mon_if.err_onehot), 16'(e_oh));
    chk("err_seq",    16'(mon_if.err_seq),    16'(e_seq));
    chk("err_len",    16'(mon_if.err_len),    16'(e_len));
    chk("err_stuck",  16'(mon_if.err_stuck),  16'(e_st));
    chk("err_any",    16'(mon_if.err_any),    16'(any_m));
  endtask

  task automatic tick();
    rst_h[cyc] = rst;
    ph_h[cyc]  = dec(mon_if.red, mon_if.green, mon_if.yellow);
    cnd_h[cyc] = mon_if.condition;
    clr_h[cyc] = mon_if.clr_err;
    @(posedge clk);
    #1;
    cyc++;
    model_check(cyc);
  endtask

  task automatic lamps(input bit [1:0] p);
    logic [2:0] bad;
    case (p)
      2'd0: {mon_if.red, mon_if.green, mon_if.yellow} = 3'b100;
      2'd1: {mon_if.red, mon_if.green, mon_if.yellow} = 3'b010;
      2'd2: {mon_if.red, mon_if.green, mon_if.yellow} = 3'b001;
      default: begin
        case ($urandom_range(0, 4))
          0:       bad = 3'b000;
          1:       bad = 3'b110;
          2:       bad = 3'b011;
          3:       bad = 3'b101;
          default: bad = 3'b111;
        endcase
        {mon_if.red, mon_if.green, mon_if.yellow} = bad;
      end
    endcase
  endtask

  task automatic hold(input bit [1:0] p, input int len);
    for (int i = 0; i < len; i++) begin
      lamps(p);
      tick();
    end
  endtask

  initial begin
    bit [1:0] p;
    int len, a;
    mon_if.condition = 1'b0;
    mon_if.clr_err   = 1'b0;
    lamps(0);
    // Reset with the controller showing RED
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    // Three normal rounds, condition low
    repeat (3) begin hold(0, 32); hold(1, 32); hold(2, 5); end
    // Condition held high
    mon_if.condition = 1'b1;
    repeat (2) begin hold(0, 64); hold(1, 64); hold(2, 5); end
    mon_if.condition = 1'b0;
    // One-cycle bad pattern mid-GREEN; the GREEN after it is not checked
    hold(0, 32); hold(1, 10);
    {mon_if.red, mon_if.green, mon_if.yellow} = 3'b110; tick();
    hold(1, 22); hold(2, 5);
    hold(0, 31);
    lamps(0); mon_if.clr_err = 1'b1; tick(); mon_if.clr_err = 1'b0;
    // GREEN -> RED directly, then a short YELLOW
    hold(1, 32); hold(0, 32); hold(1, 32); hold(2, 4);
    // Stuck RED
    hold(0, 250); hold(1, 32); hold(2, 5);
    lamps(0); mon_if.clr_err = 1'b1; tick(); mon_if.clr_err = 1'b0;
    hold(0, 31);
    // Condition toggles mid-GREEN
    hold(1, 10); mon_if.condition = 1'b1; hold(1, 30); mon_if.condition = 1'b0;
    hold(2, 5);
    // Randomised phases
    p = 2'd0;
    repeat (60) begin
      mon_if.condition = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1:    len = (p == 2) ? 5 : (mon_if.condition ? 64 : 32);
        2:       len = $urandom_range(1, 80);
        default: len = (p == 2) ? $urandom_range(3, 7) : $urandom_range(28, 68);
      endcase
      lamps(p);
      mon_if.clr_err = ($urandom_range(0, 3) == 0);
      tick();
      mon_if.clr_err = 1'b0;
      if (len > 2 && $urandom_range(0, 3) == 0) begin
        a = $urandom_range(1, len - 2);
        hold(p, a);
        mon_if.condition = ~mon_if.condition;
        hold(p, len - 1 - a);
      end else begin
        hold(p, len - 1);
      end
      if ($urandom_range(0, 7) == 0) p = 2'($urandom_range(0, 3));
      else                           p = (p == 2'd0) ? 2'd1 : (p == 2'd1) ? 2'd2 : 2'd0;
    end
    // Reset in the middle of RED: the aborted phase yields no length
    mon_if.condition = 1'b0;
    hold(0, 10);
    rst = 1'b1; lamps(0); tick(); rst = 1'b0;
    hold(0, 20); hold(1, 32); hold(2, 5); hold(0, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
